// File: rtl/uart_tx_arbiter_if.sv
// Request/transmit bundle between the byte producers, the round-robin
// arbiter and the shared UART transmitter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid_in;
    logic [NUM_REQ-1:0][7:0]  req_data_in;
    logic [NUM_REQ-1:0]       req_last_in;
    logic [NUM_REQ-1:0]       req_ready_out;
    logic [7:0]               uart_data_out;
    logic                     uart_trigger_out;
    logic                     uart_busy_in;
    logic [GW-1:0]            grant_out;
    logic                     lock_out;
    logic                     error_out;

    modport slave (
        input  req_valid_in, req_data_in, req_last_in, uart_busy_in,
        output req_ready_out, uart_data_out, uart_trigger_out,
               grant_out, lock_out, error_out
    );

    modport master (
        output req_valid_in, req_data_in, req_last_in, uart_busy_in,
        input  req_ready_out, uart_data_out, uart_trigger_out,
               grant_out, lock_out, error_out
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one shared UART transmitter; a grant stays
// locked on its requester until that requester's last byte is accepted.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    uart_tx_arbiter_if.slave  bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(START_TIMEOUT + 1) + 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(START_TIMEOUT - 1);
    localparam logic [GW-1:0] PTR_RST  = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t          state_q;
    logic [GW-1:0]   rr_ptr_q;
    logic [GW-1:0]   grant_q;
    logic            lock_q;
    logic            error_q;
    logic            trigger_q;
    logic [7:0]      data_q;
    logic [CW-1:0]   tmo_cnt_q;

    logic            sel_found_d;
    logic [GW-1:0]   sel_idx_d;
    logic [GW-1:0]   cand_d;
    logic            accept_d;

    // Descending scan so the candidate nearest rr_ptr+1 is the one left standing.
    always_comb begin
        sel_found_d = 1'b0;
        sel_idx_d   = grant_q;
        cand_d      = '0;
        if (lock_q) begin
            sel_found_d = bus.req_valid_in[grant_q];
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                cand_d = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
                if (bus.req_valid_in[cand_d]) begin
                    sel_found_d = 1'b1;
                    sel_idx_d   = cand_d;
                end
            end
        end
    end

    assign accept_d = (state_q == IDLE) && sel_found_d && !rst_in;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.req_ready_out[gi] = accept_d && (sel_idx_d == GW'(gi));
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            rr_ptr_q  <= PTR_RST;
            grant_q   <= '0;
            lock_q    <= 1'b0;
            error_q   <= 1'b0;
            trigger_q <= 1'b0;
            data_q    <= '0;
            tmo_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_found_d) begin
                        data_q    <= bus.req_data_in[sel_idx_d];
                        grant_q   <= sel_idx_d;
                        trigger_q <= 1'b1;
                        state_q   <= SEND;
                        if (bus.req_last_in[sel_idx_d]) begin
                            lock_q   <= 1'b0;
                            rr_ptr_q <= sel_idx_d;
                        end else begin
                            lock_q   <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    // The trigger cycle itself counts toward the start timeout.
                    trigger_q <= 1'b0;
                    tmo_cnt_q <= CW'(1);
                    state_q   <= WAIT_START;
                end
                WAIT_START: begin
                    if (bus.uart_busy_in) begin
                        state_q <= WAIT_DONE;
                    end else if (tmo_cnt_q >= TMO_LAST) begin
                        error_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!bus.uart_busy_in) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.uart_data_out    = data_q;
    assign bus.uart_trigger_out = trigger_q;
    assign bus.grant_out        = grant_q;
    assign bus.lock_out         = lock_q;
    assign bus.error_out        = error_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART transmitter,
// a line receiver and per-requester byte programs.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int TMO = 4;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TMO)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Transmitter model: busy registered one cycle after the trigger.
    logic       model_en = 1'b1;
    logic       busy_q   = 1'b0;
    logic       tx_line  = 1'b1;
    logic [9:0] frame    = '0;
    int         bit_n    = 0;
    int         tick     = 0;

    always @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            tx_line <= 1'b1;
        end else if (!busy_q) begin
            if (bus.uart_trigger_out && model_en) begin
                busy_q  <= 1'b1;
                frame   <= {1'b1, bus.uart_data_out, 1'b0};
                tx_line <= 1'b0;
                bit_n   <= 0;
                tick    <= 0;
            end
        end else if (tick == CPB - 1) begin
            tick <= 0;
            if (bit_n == 9) begin
                busy_q  <= 1'b0;
                tx_line <= 1'b1;
            end else begin
                bit_n   <= bit_n + 1;
                tx_line <= frame[bit_n + 1];
            end
        end else begin
            tick <= tick + 1;
        end
    end
    assign bus.uart_busy_in = busy_q;

    // Line receiver: raw 10-bit frames {stop, data, start}.
    logic [9:0] rx_q[$];
    always begin : rx_proc
        logic [9:0] f;
        @(negedge tx_line);
        for (int b = 0; b < 10; b++) begin
            repeat ((b == 0) ? CPB / 2 : CPB) @(negedge clk);
            f[b] = tx_line;
        end
        if (!rst) rx_q.push_back(f);
    end

    // Monitor: logs triggers and acceptances, counts invariant violations.
    int         cyc = 0;
    int         trig_cyc[$];
    logic [7:0] trig_data[$];
    int         trig_grant[$];
    logic       trig_lock[$];
    int         rdy_idx[$];
    int         rdy_cyc[$];
    int         acc_cnt[N];
    int         busy_rise = 0;
    int         err_cyc   = -1;
    int         inv_viol  = 0;
    logic       busy_prev = 1'b0;
    logic       err_prev  = 1'b0;

    initial for (int i = 0; i < N; i++) acc_cnt[i] = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (!$onehot0(bus.req_ready_out) || (bus.uart_trigger_out && bus.uart_busy_in))
                inv_viol++;
            if (bus.uart_trigger_out) begin
                trig_cyc.push_back(cyc);
                trig_data.push_back(bus.uart_data_out);
                trig_grant.push_back(int'(bus.grant_out));
                trig_lock.push_back(bus.lock_out);
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready_out[i] && bus.req_valid_in[i]) begin
                    acc_cnt[i]++;
                    rdy_idx.push_back(i);
                    rdy_cyc.push_back(cyc);
                end
            end
            if (bus.uart_busy_in && !busy_prev) busy_rise++;
            if (bus.error_out && !err_prev) err_cyc = cyc;
        end
        busy_prev = bus.uart_busy_in;
        err_prev  = bus.error_out;
    end

    // Requester programs: {last, data} per slot, advanced by accepted handshakes.
    logic [8:0] prog_data[N][16];
    int         prog_start[N];
    int         prog_len[N];

    initial begin
        for (int i = 0; i < N; i++) begin
            prog_start[i] = 0;
            prog_len[i]   = 0;
        end
    end

    initial begin
        bus.req_valid_in = '0;
        bus.req_data_in  = '0;
        bus.req_last_in  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                int k;
                k = acc_cnt[i] - prog_start[i];
                if (k < prog_len[i]) begin
                    bus.req_valid_in[i] = 1'b1;
                    bus.req_data_in[i]  = prog_data[i][k][7:0];
                    bus.req_last_in[i]  = prog_data[i][k][8];
                end else begin
                    bus.req_valid_in[i] = 1'b0;
                    bus.req_data_in[i]  = 8'h00;
                    bus.req_last_in[i]  = 1'b0;
                end
            end
        end
    end

    task automatic load(input int r, input int k, input logic [8:0] v);
        prog_data[r][k] = v;
    endtask

    task automatic arm(input int r, input int len);
        prog_start[r] = acc_cnt[r];
        prog_len[r]   = len;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) prog_len[i] = 0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_quiet(input int budget, input string tag);
        int q;
        int t;
        bool_loop: begin
            q = 0;
            t = 0;
            while (q < 8 && t < budget) begin
                logic done;
                @(negedge clk);
                t++;
                done = 1'b1;
                for (int i = 0; i < N; i++)
                    if (acc_cnt[i] - prog_start[i] < prog_len[i]) done = 1'b0;
                if (done && !bus.uart_busy_in && !bus.uart_trigger_out) q++;
                else q = 0;
            end
        end
        n_checks++;
        if (q < 8) begin
            n_fail++;
            $display("FAIL %s_drain: still active after %0d cycles, required idle", tag, budget);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (bus.req_ready_out !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready_out); end
        n_checks++; if (bus.uart_trigger_out !== 1'b0) begin n_fail++; $display("FAIL reset_trigger: got %b want 0", bus.uart_trigger_out); end
        n_checks++; if (bus.uart_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.uart_data_out); end
        n_checks++; if (bus.grant_out !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", bus.grant_out); end
        n_checks++; if (bus.lock_out !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b want 0", bus.lock_out); end
        n_checks++; if (bus.error_out !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", bus.error_out); end
        #1;
        rst = 1'b0;
        $display("test_reset: done, checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_single_byte();
        int bt = trig_data.size();
        int br = rdy_idx.size();
        int bx = rx_q.size();
        int iv = inv_viol;
        load(2, 0, {1'b1, 8'h41});
        arm(2, 1);
        wait_quiet(200, "single");
        n_checks++;
        if (rdy_idx.size() - br !== 1 || rdy_idx[br] !== 2) begin
            n_fail++; $display("FAIL single_ready: %0d acceptances first idx %0d, want 1 on idx 2", rdy_idx.size() - br, rdy_idx[br]);
        end
        n_checks++;
        if (trig_data.size() - bt !== 1) begin
            n_fail++; $display("FAIL single_trig_count: got %0d want 1", trig_data.size() - bt);
        end else begin
            n_checks++; if (trig_data[bt] !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h want 41", trig_data[bt]); end
            n_checks++; if (trig_grant[bt] !== 2) begin n_fail++; $display("FAIL single_grant: got %0d want 2", trig_grant[bt]); end
            n_checks++; if (trig_cyc[bt] !== rdy_cyc[br] + 1) begin n_fail++; $display("FAIL single_latency: trigger cycle %0d want %0d", trig_cyc[bt], rdy_cyc[br] + 1); end
        end
        n_checks++;
        if (rx_q.size() - bx !== 1 || rx_q[bx] !== 10'b1_0100_0001_0) begin
            n_fail++; $display("FAIL single_line: %0d frames first %b, want 1 frame 1010000010", rx_q.size() - bx, rx_q[bx]);
        end
        n_checks++; if (inv_viol !== iv) begin n_fail++; $display("FAIL single_invariant: %0d violations want 0", inv_viol - iv); end
        $display("test_single_byte: done, checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_round_robin();
        int ids[3] = '{0, 1, 3};
        int bt, bx, bb, iv;
        do_reset();
        bt = trig_data.size(); bx = rx_q.size(); bb = busy_rise; iv = inv_viol;
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 3; k++)
                load(ids[j], k, {1'b1, 4'(ids[j]), 4'(k)});
        for (int j = 0; j < 3; j++) arm(ids[j], 3);
        wait_quiet(2000, "rr");
        n_checks++;
        if (trig_data.size() - bt !== 9 || busy_rise - bb !== 9) begin
            n_fail++; $display("FAIL rr_count: triggers %0d busy cycles %0d, want 9 and 9", trig_data.size() - bt, busy_rise - bb);
        end else begin
            for (int n = 0; n < 9; n++) begin
                logic [7:0] exp_d;
                exp_d = {4'(ids[n % 3]), 4'(n / 3)};
                n_checks++;
                if (trig_grant[bt + n] !== ids[n % 3] || trig_data[bt + n] !== exp_d ||
                    rx_q[bx + n] !== {1'b1, exp_d, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: grant %0d data %h line %b, want grant %0d data %h",
                             n, trig_grant[bt + n], trig_data[bt + n], rx_q[bx + n], ids[n % 3], exp_d);
                end
            end
        end
        n_checks++; if (inv_viol !== iv) begin n_fail++; $display("FAIL rr_invariant: %0d violations want 0", inv_viol - iv); end
        $display("test_round_robin: done, checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_packet_lock();
        int         eg[5] = '{0, 1, 1, 1, 0};
        logic [7:0] ed[5] = '{8'h01, 8'h10, 8'h11, 8'h12, 8'h02};
        logic       el[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int bt, iv;
        do_reset();
        bt = trig_data.size(); iv = inv_viol;
        load(0, 0, {1'b1, 8'h01});
        load(0, 1, {1'b1, 8'h02});
        load(1, 0, {1'b0, 8'h10});
        load(1, 1, {1'b0, 8'h11});
        load(1, 2, {1'b1, 8'h12});
        arm(0, 2);
        arm(1, 3);
        wait_quiet(1500, "lock");
        n_checks++;
        if (trig_data.size() - bt !== 5) begin
            n_fail++; $display("FAIL lock_count: got %0d triggers want 5", trig_data.size() - bt);
        end else begin
            for (int n = 0; n < 5; n++) begin
                n_checks++;
                if (trig_grant[bt + n] !== eg[n] || trig_data[bt + n] !== ed[n] || trig_lock[bt + n] !== el[n]) begin
                    n_fail++;
                    $display("FAIL lock_seq[%0d]: grant %0d data %h lock %b, want grant %0d data %h lock %b",
                             n, trig_grant[bt + n], trig_data[bt + n], trig_lock[bt + n], eg[n], ed[n], el[n]);
                end
            end
        end
        n_checks++; if (inv_viol !== iv) begin n_fail++; $display("FAIL lock_invariant: %0d violations want 0", inv_viol - iv); end
        $display("test_packet_lock: done, checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_stalled_lock();
        int bt = trig_data.size();
        int a2;
        load(1, 0, {1'b0, 8'h20});
        load(2, 0, {1'b1, 8'h30});
        arm(1, 1);
        arm(2, 1);
        a2 = acc_cnt[2];
        repeat (60) @(negedge clk);
        repeat (50) @(negedge clk);
        n_checks++;
        if (trig_data.size() - bt !== 1 || trig_grant[bt] !== 1 || trig_data[bt] !== 8'h20) begin
            n_fail++; $display("FAIL stall_first: %0d triggers grant %0d data %h, want 1 trigger grant 1 data 20",
                               trig_data.size() - bt, trig_grant[bt], trig_data[bt]);
        end
        n_checks++; if (bus.lock_out !== 1'b1) begin n_fail++; $display("FAIL stall_lock: got %b want 1", bus.lock_out); end
        n_checks++; if (acc_cnt[2] !== a2 || bus.req_ready_out !== 4'b0000) begin
            n_fail++; $display("FAIL stall_ready: req2 accepted %0d ready %b, want 0 and 0000", acc_cnt[2] - a2, bus.req_ready_out);
        end
        load(1, 0, {1'b1, 8'h21});
        arm(1, 1);
        wait_quiet(500, "stall");
        n_checks++;
        if (trig_data.size() - bt !== 3 || trig_grant[bt + 1] !== 1 || trig_data[bt + 1] !== 8'h21 ||
            trig_grant[bt + 2] !== 2 || trig_data[bt + 2] !== 8'h30) begin
            n_fail++; $display("FAIL stall_resume: %0d triggers then (%0d,%h) (%0d,%h), want 3 with (1,21) (2,30)",
                               trig_data.size() - bt, trig_grant[bt + 1], trig_data[bt + 1], trig_grant[bt + 2], trig_data[bt + 2]);
        end
        $display("test_stalled_lock: done, checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_timeout();
        int bt = trig_data.size();
        model_en = 1'b0;
        load(0, 0, {1'b1, 8'h55});
        load(0, 1, {1'b1, 8'h56});
        arm(0, 2);
        wait_quiet(200, "timeout");
        n_checks++;
        if (trig_data.size() - bt !== 2 || trig_data[bt] !== 8'h55 || trig_data[bt + 1] !== 8'h56) begin
            n_fail++; $display("FAIL tmo_bytes: %0d triggers data %h %h, want 2 with 55 56",
                               trig_data.size() - bt, trig_data[bt], trig_data[bt + 1]);
        end else begin
            n_checks++; if (err_cyc !== trig_cyc[bt] + TMO) begin n_fail++; $display("FAIL tmo_error_cycle: got %0d want %0d", err_cyc, trig_cyc[bt] + TMO); end
            n_checks++; if (trig_cyc[bt + 1] !== trig_cyc[bt] + TMO + 1) begin n_fail++; $display("FAIL tmo_next_trigger: got %0d want %0d", trig_cyc[bt + 1], trig_cyc[bt] + TMO + 1); end
        end
        n_checks++; if (bus.error_out !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", bus.error_out); end
        model_en = 1'b1;
        $display("test_timeout: done, checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_reset_mid();
        int bt;
        int t = 0;
        load(2, 0, {1'b0, 8'h70});
        load(2, 1, {1'b1, 8'h71});
        arm(2, 2);
        while (!bus.uart_busy_in && t < 30) begin @(negedge clk); t++; end
        n_checks++; if (!bus.uart_busy_in) begin n_fail++; $display("FAIL mid_busy: busy %b after %0d cycles want 1", bus.uart_busy_in, t); end
        load(1, 0, {1'b1, 8'h60});
        load(3, 0, {1'b1, 8'h80});
        arm(1, 1);
        arm(3, 1);
        repeat (5) @(negedge clk);
        n_checks++; if (bus.lock_out !== 1'b1 || bus.grant_out !== 2'd2) begin n_fail++; $display("FAIL mid_locked: lock %b grant %0d want 1 and 2", bus.lock_out, bus.grant_out); end
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready_out !== 4'b0000 || bus.uart_trigger_out !== 1'b0 || bus.uart_data_out !== 8'h00 ||
            bus.grant_out !== 2'd0 || bus.lock_out !== 1'b0 || bus.error_out !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_values: ready %b trig %b data %h grant %0d lock %b err %b, want all zero",
                               bus.req_ready_out, bus.uart_trigger_out, bus.uart_data_out, bus.grant_out, bus.lock_out, bus.error_out);
        end
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        bt = trig_data.size();
        t = 0;
        while (trig_data.size() == bt && t < 30) begin @(negedge clk); t++; end
        n_checks++;
        if (trig_data.size() == bt || trig_grant[bt] !== 1 || trig_data[bt] !== 8'h60) begin
            n_fail++; $display("FAIL mid_regrant: %0d triggers grant %0d data %h, want grant 1 data 60",
                               trig_data.size() - bt, trig_grant[bt], trig_data[bt]);
        end
        wait_quiet(1000, "mid");
        $display("test_reset_mid: done, checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_stalled_lock();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
